scan_filter_ctrl: RTL and testbench

//  Sequencer for the RAM-scan datapath. A start button triggers one scan of a source RAM.

---
 rtl/scan_filter_ctrl.sv | 141 ++++++++++++++
 tb/tb_scan_filter_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_filter_ctrl.sv
// Sequencer for the RAM-scan datapath: on a button edge, scans a source RAM and copies
// every word strictly above a captured threshold into consecutive destination locations.
module scan_filter_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn,
    input  logic [DW-1:0] thresh,
    input  logic [DW-1:0] src_data,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst_data,
    output logic          dst_we,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done
);

    localparam int unsigned N  = 2 ** AW;
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FETCH = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_btn_q;
    logic [AW-1:0] r_src_addr;
    logic [AW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_thr_q;

    state_t        w_state_nxt;
    logic [AW-1:0] w_src_addr_nxt;
    logic [AW-1:0] w_wptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [DW-1:0] w_thr_nxt;
    logic          w_start;
    logic          w_hit;
    logic          w_we;
    logic [DW-1:0] w_wdata;
    logic          w_busy;
    logic          w_done;

    assign w_start = btn & ~r_btn_q;
    assign w_hit   = src_data > r_thr_q;

    // Next-state, datapath updates and Moore/Mealy outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_src_addr_nxt = r_src_addr;
        w_wptr_nxt     = r_wptr;
        w_count_nxt    = r_count;
        w_thr_nxt      = r_thr_q;
        w_we           = 1'b0;
        w_wdata        = '0;
        w_busy         = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                w_busy         = 1'b1;
                w_src_addr_nxt = '0;
                w_wptr_nxt     = '0;
                w_count_nxt    = '0;
                w_thr_nxt      = thresh;
                w_state_nxt    = S_FETCH;
            end
            S_FETCH: begin
                w_busy      = 1'b1;
                w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                w_busy = 1'b1;
                if (w_hit) begin
                    w_we        = 1'b1;
                    w_wdata     = src_data;
                    w_wptr_nxt  = r_wptr + AW'(1);
                    w_count_nxt = r_count + CW'(1);
                end
                if (r_src_addr == LAST_ADDR) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_src_addr_nxt = r_src_addr + AW'(1);
                    w_state_nxt    = S_FETCH;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_src_addr_nxt = '0;
                w_wptr_nxt     = '0;
                w_count_nxt    = '0;
                w_thr_nxt      = '0;
            end
        endcase
    end

    // btn_q resets high so a button held through reset cannot start a scan
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_btn_q    <= 1'b1;
            r_src_addr <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_thr_q    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_q    <= btn;
            r_src_addr <= w_src_addr_nxt;
            r_wptr     <= w_wptr_nxt;
            r_count    <= w_count_nxt;
            r_thr_q    <= w_thr_nxt;
        end
    end

    // Write strobe is suppressed while reset is asserted, even mid-EVAL
    assign dst_we   = w_we & ~rst;
    assign dst_data = rst ? '0 : w_wdata;
    assign dst_addr = r_wptr;
    assign src_addr = r_src_addr;
    assign count    = r_count;
    assign busy     = w_busy;
    assign done     = w_done;

endmodule

// File: tb/tb_scan_filter_ctrl.sv
// Directed self-checking bench for scan_filter_ctrl with behavioural source/destination RAMs.
module tb_scan_filter_ctrl;

    logic       clk;
    logic       rst;
    logic       btn;
    logic [7:0] thresh;
    logic [7:0] src_q;
    logic [3:0] src_addr;
    logic [3:0] dst_addr;
    logic [7:0] dst_data;
    logic       dst_we;
    logic [4:0] count;
    logic       busy;
    logic       done;

    logic [7:0] src_mem [16];
    logic [7:0] dst_mem [16];
    logic [3:0] wr_addr [512];
    int         n_wr;
    int         n_done;
    int         n_pass;
    int         n_total;

    scan_filter_ctrl #(.AW(4), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .thresh   (thresh),
        .src_data (src_q),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_we   (dst_we),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_wr   = 0;
        n_done = 0;
        src_q  = 8'h00;
    end

    // Synchronous-read source RAM, write-only destination RAM, event log
    always @(posedge clk) begin
        src_q <= src_mem[src_addr];
        if (dst_we) begin
            dst_mem[dst_addr] <= dst_data;
            wr_addr[n_wr]     <= dst_addr;
            n_wr              <= n_wr + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 16; i++) src_mem[i] = v;
    endtask

    // Edge on btn, then run 36 cycles recording the first done cycle (-1 if none)
    task automatic do_scan(input logic [7:0] th, output int dc);
        dc     = -1;
        thresh = th;
        btn    = 1'b0;
        tick();
        btn = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (done && dc < 0) dc = c;
        end
    endtask

    task automatic test_reset();
        int seen;
        seen   = 0;
        rst    = 1'b1;
        btn    = 1'b1;
        thresh = 8'h00;
        tick(); tick(); tick();
        n_total++;
        if ({busy, done, dst_we, src_addr, dst_addr, count, dst_data} !== 23'd0) begin
            $display("FAIL reset_outputs got=%h exp=0",
                     {busy, done, dst_we, src_addr, dst_addr, count, dst_data});
        end else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (busy || done || dst_we) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL held_btn_no_start active_cycles=%0d exp=0", seen);
        else n_pass++;
    endtask

    task automatic test_basic();
        int dc;
        int base;
        int ok;
        fill_ramp();
        base = n_wr;
        do_scan(8'd9, dc);
        n_total++;
        if (dc !== 34) $display("FAIL basic_done_cycle got=%0d exp=34", dc); else n_pass++;
        n_total++;
        if (count !== 5'd6) $display("FAIL basic_count got=%0d exp=6", count); else n_pass++;
        n_total++;
        if (n_wr - base !== 6) $display("FAIL basic_writes got=%0d exp=6", n_wr - base);
        else n_pass++;
        ok = 1;
        for (int k = 0; k < 6; k++) if (dst_mem[k] !== 8'(10 + k)) ok = 0;
        n_total++;
        if (ok !== 1) $display("FAIL basic_dst_data got=%h,%h,..,%h exp=0a..0f",
                              dst_mem[0], dst_mem[1], dst_mem[5]);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL basic_idle_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_boundaries();
        int dc;
        int base;
        int ok;
        fill_const(8'hFF);
        base = n_wr;
        do_scan(8'h00, dc);
        n_total++;
        if (count !== 5'h10) $display("FAIL full_count got=%h exp=10", count); else n_pass++;
        n_total++;
        if (n_wr - base !== 16) $display("FAIL full_writes got=%0d exp=16", n_wr - base);
        else n_pass++;
        ok = 1;
        for (int k = 0; k < 16; k++) if (wr_addr[base + k] !== 4'(k)) ok = 0;
        n_total++;
        if (ok !== 1) $display("FAIL full_addr_order got=%h,%h exp=0,f",
                              wr_addr[base], wr_addr[base + 15]);
        else n_pass++;
        n_total++;
        if (dst_addr !== 4'd0) $display("FAIL full_wptr_wrap got=%h exp=0", dst_addr); else n_pass++;

        fill_const(8'h05);
        base = n_wr;
        do_scan(8'h05, dc);
        n_total++;
        if (count !== 5'd0) $display("FAIL equal_count got=%0d exp=0", count); else n_pass++;
        n_total++;
        if (n_wr - base !== 0) $display("FAIL equal_writes got=%0d exp=0", n_wr - base);
        else n_pass++;
        n_total++;
        if (dc !== 34) $display("FAIL equal_done_cycle got=%0d exp=34", dc); else n_pass++;
    endtask

    task automatic test_ignored_inputs();
        int dc;
        int base;
        int dbase;
        int ok;
        fill_ramp();
        base   = n_wr;
        dbase  = n_done;
        dc     = -1;
        thresh = 8'd9;
        btn    = 1'b0;
        tick();
        btn = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done && dc < 0) dc = c;
            if (c == 5)  thresh = 8'd0;
            if (c == 10) btn = 1'b0;
            if (c == 11) btn = 1'b1;
        end
        n_total++;
        if (count !== 5'd6) $display("FAIL ign_count got=%0d exp=6", count); else n_pass++;
        n_total++;
        if (n_wr - base !== 6) $display("FAIL ign_writes got=%0d exp=6", n_wr - base);
        else n_pass++;
        ok = 1;
        for (int k = 0; k < 6; k++) if (dst_mem[k] !== 8'(10 + k)) ok = 0;
        n_total++;
        if (ok !== 1) $display("FAIL ign_dst_data got=%h..%h exp=0a..0f", dst_mem[0], dst_mem[5]);
        else n_pass++;
        n_total++;
        if (n_done - dbase !== 1) $display("FAIL ign_done_pulses got=%0d exp=1", n_done - dbase);
        else n_pass++;
        n_total++;
        if (dc !== 34) $display("FAIL ign_done_cycle got=%0d exp=34", dc); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int dc;
        int base;
        int ok;
        fill_ramp();
        base   = n_wr;
        thresh = 8'd2;
        btn    = 1'b0;
        tick();
        btn = 1'b1;
        for (int c = 1; c <= 13; c++) tick();
        // cycle 13 is the EVAL of word 5 (5 > 2), so only reset can block this write
        rst = 1'b1;
        #1;
        n_total++;
        if (dst_we !== 1'b0) $display("FAIL rst_cycle_we got=%b exp=0", dst_we); else n_pass++;
        tick();
        rst = 1'b0;
        n_total++;
        if ({busy, dst_we, count, src_addr, dst_addr} !== 15'd0)
            $display("FAIL rst_idle_state got=%h exp=0", {busy, dst_we, count, src_addr, dst_addr});
        else n_pass++;
        n_total++;
        if (n_wr - base !== 2) $display("FAIL rst_partial_writes got=%0d exp=2", n_wr - base);
        else n_pass++;
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_no_restart got=%b exp=0", busy); else n_pass++;

        base = n_wr;
        do_scan(8'd2, dc);
        n_total++;
        if (count !== 5'd13) $display("FAIL rst_rescan_count got=%0d exp=13", count); else n_pass++;
        n_total++;
        if (n_wr - base !== 13) $display("FAIL rst_rescan_writes got=%0d exp=13", n_wr - base);
        else n_pass++;
        ok = 1;
        for (int k = 0; k < 13; k++) if (dst_mem[k] !== 8'(3 + k)) ok = 0;
        n_total++;
        if (ok !== 1) $display("FAIL rst_rescan_data got=%h..%h exp=03..0f", dst_mem[0], dst_mem[12]);
        else n_pass++;
        n_total++;
        if (dc !== 34) $display("FAIL rst_rescan_done got=%0d exp=34", dc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dc;
        fill_ramp();
        thresh = 8'd12;
        btn    = 1'b0;
        tick();
        btn = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 20) btn = 1'b0;
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL b2b_first_done got=%b exp=1", done); else n_pass++;
        n_total++;
        if (count !== 5'd3) $display("FAIL b2b_first_count got=%0d exp=3", count); else n_pass++;
        tick();
        btn = 1'b1;
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL b2b_idle got=%b exp=00", {busy, done});
        else n_pass++;
        tick();
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_second_start got=%b exp=1", busy); else n_pass++;
        tick();
        n_total++;
        if (count !== 5'd0) $display("FAIL b2b_count_restart got=%0d exp=0", count); else n_pass++;
        dc = -1;
        for (int c = 3; c <= 36; c++) begin
            tick();
            if (done && dc < 0) dc = c;
        end
        n_total++;
        if (dc !== 34) $display("FAIL b2b_second_done got=%0d exp=34", dc); else n_pass++;
        n_total++;
        if (count !== 5'd3) $display("FAIL b2b_second_count got=%0d exp=3", count); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        btn     = 1'b1;
        thresh  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            src_mem[i] = 8'h00;
            dst_mem[i] = 8'h00;
        end
        test_reset();
        test_basic();
        test_boundaries();
        test_ignored_inputs();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
